blur_frame_sequencer: RTL and testbench

//  Frame-level controller in front of the 3x3 blur/contrast pipeline.

---
 rtl/blur_frame_sequencer_if.sv | 31 +++
 rtl/blur_frame_sequencer.sv | 166 ++++++++++++++++
 tb/tb_blur_frame_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/blur_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : blur_frame_sequencer_if
// Brief    : Camera-side pixel stream and filter-side pixel/status bundle.
// Revision : 1.0
// ============================================================================
interface blur_frame_sequencer_if;
   logic       frame_start;
   logic       pix_valid;
   logic [3:0] pix_data;
   logic       mode_btn;
   logic [9:0] x_coor;
   logic [8:0] y_coor;
   logic       de;
   logic [3:0] o_data;
   logic [1:0] mode;
   logic       busy;
   logic       frame_done;
   logic       overrun;

   modport master (
      output frame_start, pix_valid, pix_data, mode_btn,
      input  x_coor, y_coor, de, o_data, mode, busy, frame_done, overrun
   );

   modport slave (
      input  frame_start, pix_valid, pix_data, mode_btn,
      output x_coor, y_coor, de, o_data, mode, busy, frame_done, overrun
   );
endinterface
`default_nettype wire

// File: rtl/blur_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : blur_frame_sequencer
// Brief    : Frame controller ahead of the blur pipeline: raster coordinates,
//            frame-boundary mode commit, completion and overrun reporting.
// Revision : 1.0
// ============================================================================
module blur_frame_sequencer #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int NUM_MODES  = 3
) (
   input wire                    clk,
   input wire                    reset,
   blur_frame_sequencer_if.slave pix_if
);

   localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam logic [XW-1:0] X_LAST    = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST    = YW'(IMG_HEIGHT - 1);
   localparam logic [1:0]    MODE_LAST = 2'(NUM_MODES - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [XW-1:0] cx_q, cx_d;
   logic [YW-1:0] cy_q, cy_d;
   logic [9:0]    x_q, x_d;
   logic [8:0]    y_q, y_d;
   logic          de_q, de_d;
   logic [3:0]    data_q, data_d;
   logic [1:0]    mode_q, mode_d;
   logic [1:0]    pend_q, pend_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          ovr_q, ovr_d;

   logic          commit;
   logic          last_pix;
   logic [XW-1:0] px;
   logic [YW-1:0] py;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cx_q    <= '0;
         cy_q    <= '0;
         x_q     <= '0;
         y_q     <= '0;
         de_q    <= 1'b0;
         data_q  <= '0;
         mode_q  <= '0;
         pend_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         x_q     <= x_d;
         y_q     <= y_d;
         de_q    <= de_d;
         data_q  <= data_d;
         mode_q  <= mode_d;
         pend_q  <= pend_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cx_d     = cx_q;
      cy_d     = cy_q;
      x_d      = x_q;
      y_d      = y_q;
      de_d     = 1'b0;
      data_d   = data_q;
      mode_d   = mode_q;
      done_d   = 1'b0;
      ovr_d    = ovr_q;
      commit   = 1'b0;
      last_pix = 1'b0;
      px       = cx_q;
      py       = cy_q;

      // A press in the commit cycle lands after the commit, so it targets the next frame.
      if (pix_if.mode_btn) begin
         pend_d = (pend_q == MODE_LAST) ? 2'd0 : pend_q + 2'd1;
      end else begin
         pend_d = pend_q;
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            cx_d = '0;
            cy_d = '0;
            if (pix_if.frame_start) begin
               state_d = S_ACTIVE;
               commit  = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_ACTIVE: begin
            last_pix = pix_if.pix_valid && (cx_q == X_LAST) && (cy_q == Y_LAST);
            // A restart abandons the frame; a same-cycle pixel is the new frame's first.
            if (pix_if.frame_start && !last_pix) begin
               ovr_d  = 1'b1;
               commit = 1'b1;
               px     = '0;
               py     = '0;
            end
            if (pix_if.pix_valid) begin
               de_d   = 1'b1;
               data_d = pix_if.pix_data;
               x_d    = 10'(px);
               y_d    = 9'(py);
               if (last_pix) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  cx_d    = '0;
                  cy_d    = '0;
               end else if (px == X_LAST) begin
                  cx_d = '0;
                  cy_d = py + YW'(1);
               end else begin
                  cx_d = px + XW'(1);
                  cy_d = py;
               end
            end else begin
               cx_d = px;
               cy_d = py;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (commit) begin
         mode_d = pend_q;
      end
      busy_d = (state_d != S_IDLE);
   end

   assign pix_if.x_coor     = x_q;
   assign pix_if.y_coor     = y_q;
   assign pix_if.de         = de_q;
   assign pix_if.o_data     = data_q;
   assign pix_if.mode       = mode_q;
   assign pix_if.busy       = busy_q;
   assign pix_if.frame_done = done_q;
   assign pix_if.overrun    = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_blur_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_blur_frame_sequencer
// Brief    : Bench for blur_frame_sequencer with a frame-level reference model.
// Revision : 1.0
// ============================================================================
module tb_blur_frame_sequencer;
   localparam int W  = 4;
   localparam int H  = 3;
   localparam int NM = 3;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   blur_frame_sequencer_if bus ();

   blur_frame_sequencer #(
      .IMG_WIDTH (W),
      .IMG_HEIGHT(H),
      .NUM_MODES (NM)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .pix_if(bus)
   );

   always #5 clk = ~clk;

   int n_tests  = 0;
   int n_fail   = 0;
   int de_cnt   = 0;
   int done_cnt = 0;

   // Expected outputs for the cycle following each edge
   bit e_de, e_busy, e_done, e_ovr;
   int e_x, e_y, e_data, e_mode;
   bit started = 1'b0;

   // Model: a frame is a linear pixel index; coordinates are index mod/div W.
   initial begin
      bit m_active, m_fin, commit, fs, pv, btn, lastp;
      int m_idx, m_pend, d;
      m_active = 0; m_fin = 0; m_idx = 0; m_pend = 0;
      forever begin
         @(posedge clk);
         started = 1'b1;
         fs  = bus.frame_start;
         pv  = bus.pix_valid;
         btn = bus.mode_btn;
         d   = int'(bus.pix_data);
         if (!reset) begin
            m_active = 0; m_fin = 0; m_idx = 0; m_pend = 0;
            e_de = 0; e_x = 0; e_y = 0; e_data = 0; e_mode = 0;
            e_busy = 0; e_done = 0; e_ovr = 0;
         end else begin
            e_de = 0; e_done = 0; commit = 0;
            if (!m_active) begin
               m_fin = 0;
               if (fs) begin
                  m_active = 1; m_idx = 0; commit = 1;
               end
            end else begin
               lastp = pv && (m_idx == W*H-1);
               if (fs && !lastp) begin
                  e_ovr = 1; m_idx = 0; commit = 1;
               end
               if (pv) begin
                  e_de = 1; e_x = m_idx % W; e_y = m_idx / W; e_data = d;
                  if (m_idx == W*H-1) begin
                     m_active = 0; m_fin = 1; e_done = 1;
                  end else begin
                     m_idx++;
                  end
               end
            end
            if (commit) e_mode = m_pend;
            if (btn) m_pend = (m_pend + 1) % NM;
            e_busy = m_active || m_fin;
         end
      end
   end

   // Per-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         if (started) begin
            n_tests++;
            if (bus.de !== e_de || bus.mode !== 2'(e_mode) || bus.busy !== e_busy ||
                bus.frame_done !== e_done || bus.overrun !== e_ovr) begin
               n_fail++;
               $display("FAIL status @%0t: got de=%b mode=%0d busy=%b done=%b ovr=%b, expected de=%b mode=%0d busy=%b done=%b ovr=%b",
                        $time, bus.de, bus.mode, bus.busy, bus.frame_done, bus.overrun,
                        e_de, e_mode, e_busy, e_done, e_ovr);
            end
            if (e_de) begin
               n_tests++;
               if (bus.x_coor !== 10'(e_x) || bus.y_coor !== 9'(e_y) || bus.o_data !== 4'(e_data)) begin
                  n_fail++;
                  $display("FAIL pixel @%0t: got (%0d,%0d) data=%0d, expected (%0d,%0d) data=%0d",
                           $time, bus.x_coor, bus.y_coor, bus.o_data, e_x, e_y, e_data);
               end
            end
            if (bus.de === 1'b1) de_cnt++;
            if (bus.frame_done === 1'b1) done_cnt++;
         end
      end
   end

   task automatic cyc(input bit fs, input bit pv, input bit [3:0] d, input bit btn);
      @(negedge clk);
      bus.frame_start = fs;
      bus.pix_valid   = pv;
      bus.pix_data    = d;
      bus.mode_btn    = btn;
   endtask

   task automatic run_pixels(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 4'($urandom), 1'b0);
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
      end
   endtask

   initial begin
      int n;
      bit pv, fs, btn;
      bus.frame_start = 0; bus.pix_valid = 0; bus.pix_data = 0; bus.mode_btn = 0;
      reset = 0;
      repeat (3) cyc(0, 0, 0, 0);
      chk("reset_de", 32'(bus.de), 0);
      chk("reset_busy", 32'(bus.busy), 0);
      chk("reset_mode", 32'(bus.mode), 0);
      chk("reset_ovr", 32'(bus.overrun), 0);
      reset = 1;

      // Full frame, pixel every cycle
      cyc(1, 0, 0, 0);
      de_cnt = 0; done_cnt = 0;
      run_pixels(12);
      cyc(0, 0, 0, 0);
      chk("t1_last_x", 32'(bus.x_coor), 3);
      chk("t1_last_y", 32'(bus.y_coor), 2);
      chk("t1_last_de", 32'(bus.de), 1);
      chk("t1_done", 32'(bus.frame_done), 1);
      chk("t1_busy_done", 32'(bus.busy), 1);
      cyc(0, 0, 0, 0);
      chk("t1_busy_after", 32'(bus.busy), 0);
      chk("t1_de_count", 32'(de_cnt), 12);
      chk("t1_done_count", 32'(done_cnt), 1);

      // Gappy frame; pixels offered while idle and during the done cycle
      repeat (4) cyc(0, 1, 4'($urandom), 0);
      de_cnt = 0;
      cyc(1, 0, 0, 0);
      n = 0;
      while (n < 12) begin
         pv = 1'($urandom);
         cyc(0, pv, 4'($urandom), 0);
         if (pv) n++;
      end
      cyc(0, 1, 4'($urandom), 0);
      cyc(0, 1, 4'($urandom), 0);
      cyc(0, 0, 0, 0);
      chk("t2_de_count", 32'(de_cnt), 12);

      // Two presses mid-frame, committed only at next frame start
      cyc(1, 0, 0, 0);
      run_pixels(3);
      cyc(0, 1, 4'($urandom), 1);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0);
      chk("t3_mode_hold", 32'(bus.mode), 0);
      run_pixels(8);
      repeat (2) cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
      chk("t3_mode_commit", 32'(bus.mode), 2);
      cyc(0, 0, 0, 1);
      run_pixels(12);
      repeat (2) cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
      chk("t3_mode_wrap", 32'(bus.mode), 0);

      // Press coinciding with frame start
      cyc(0, 0, 0, 1);
      run_pixels(12);
      repeat (2) cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 1);
      cyc(0, 0, 0, 0);
      chk("t4_mode_same_cycle", 32'(bus.mode), 1);
      run_pixels(12);
      repeat (2) cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
      chk("t4_mode_next", 32'(bus.mode), 2);

      // Restart after 5 pixels
      done_cnt = 0;
      run_pixels(5);
      cyc(1, 0, 0, 0);
      cyc(0, 1, 4'hA, 0);
      cyc(0, 0, 0, 0);
      chk("t5_overrun", 32'(bus.overrun), 1);
      chk("t5_x", 32'(bus.x_coor), 0);
      chk("t5_y", 32'(bus.y_coor), 0);
      chk("t5_data", 32'(bus.o_data), 32'hA);
      run_pixels(2);
      cyc(1, 1, 4'h5, 0);
      cyc(0, 0, 0, 0);
      chk("t5_same_cycle_x", 32'(bus.x_coor), 0);
      chk("t5_same_cycle_data", 32'(bus.o_data), 5);
      run_pixels(11);
      repeat (2) cyc(0, 0, 0, 0);
      chk("t5_done_count", 32'(done_cnt), 1);
      chk("t5_overrun_sticky", 32'(bus.overrun), 1);

      // Reset mid-frame at pixel 7
      cyc(1, 0, 0, 0);
      run_pixels(6);
      cyc(0, 1, 4'hF, 0);
      reset = 0;
      cyc(0, 0, 0, 0);
      chk("t6_de", 32'(bus.de), 0);
      chk("t6_x", 32'(bus.x_coor), 0);
      chk("t6_data", 32'(bus.o_data), 0);
      chk("t6_mode", 32'(bus.mode), 0);
      chk("t6_busy", 32'(bus.busy), 0);
      chk("t6_done", 32'(bus.frame_done), 0);
      chk("t6_ovr", 32'(bus.overrun), 0);
      reset = 1;

      // Randomised traffic; restarts only on cycles without a pixel
      for (int i = 0; i < 3000; i++) begin
         pv  = 1'($urandom);
         fs  = !pv && ($urandom_range(0, 29) == 0);
         btn = ($urandom_range(0, 7) == 0);
         cyc(fs, pv, 4'($urandom), btn);
         reset = ($urandom_range(0, 299) != 0);
      end
      reset = 1;
      repeat (3) cyc(0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
